// File: rtl/pcs_rx_gearbox_if.sv
// Per-lane receive gearbox bus: SerDes words and slip request in, 66-bit PCS blocks out.
interface pcs_rx_gearbox_if #(
    parameter int unsigned HEAD_W = 2,
    parameter int unsigned DATA_W = 64
);
    logic              serdes_v_i;
    logic [DATA_W-1:0] serdes_data_i;
    logic              slip_i;
    logic              valid_o;
    logic [HEAD_W-1:0] head_o;
    logic [DATA_W-1:0] data_o;

    modport master (
        output serdes_v_i,
        output serdes_data_i,
        output slip_i,
        input  valid_o,
        input  head_o,
        input  data_o
    );

    modport slave (
        input  serdes_v_i,
        input  serdes_data_i,
        input  slip_i,
        output valid_o,
        output head_o,
        output data_o
    );
endinterface

// File: rtl/pcs_rx_gearbox.sv
// 64->66 receive gearbox: packs SerDes words LSB-first into sync-header + payload blocks and
// honours block-sync slip requests by discarding the oldest pending bit.
module pcs_rx_gearbox #(
    parameter int unsigned HEAD_W  = 2,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned BLOCK_W = HEAD_W + DATA_W
) (
    input logic            clk,
    input logic            nreset,
    pcs_rx_gearbox_if.slave gb
);
    localparam int unsigned BUF_W   = BLOCK_W + DATA_W - 1;
    localparam int unsigned FILL_W  = 7;
    localparam int unsigned AVAIL_W = 8;

    logic [BUF_W-1:0]   r_buf;
    logic [FILL_W-1:0]  r_fill;
    logic               r_slip_p;
    logic               r_valid;
    logic [HEAD_W-1:0]  r_head;
    logic [DATA_W-1:0]  r_data;

    logic               w_slip;
    logic [BUF_W-1:0]   w_cat;
    logic [AVAIL_W-1:0] w_avail;
    logic               w_emit;
    logic [BUF_W-1:0]   w_buf_d;
    logic [FILL_W-1:0]  w_fill_d;
    logic               w_slip_p_d;
    logic               w_valid_d;
    logic [HEAD_W-1:0]  w_head_d;
    logic [DATA_W-1:0]  w_data_d;

    always_comb begin
        // A pulse arriving with the word slips that word; extra pulses fold into one pending slip.
        w_slip  = r_slip_p | gb.slip_i;
        w_cat   = r_buf | (BUF_W'(gb.serdes_data_i) << r_fill);
        w_avail = AVAIL_W'(r_fill) + AVAIL_W'(DATA_W);
        if (w_slip) begin
            w_cat   = w_cat >> 1;
            w_avail = w_avail - AVAIL_W'(1);
        end
        w_emit = (w_avail >= AVAIL_W'(BLOCK_W));

        w_buf_d    = r_buf;
        w_fill_d   = r_fill;
        w_slip_p_d = w_slip;
        w_valid_d  = 1'b0;
        w_head_d   = r_head;
        w_data_d   = r_data;

        if (gb.serdes_v_i) begin
            w_slip_p_d = 1'b0;
            if (w_emit) begin
                w_valid_d = 1'b1;
                w_head_d  = w_cat[HEAD_W-1:0];
                w_data_d  = w_cat[BLOCK_W-1:HEAD_W];
                w_buf_d   = w_cat >> BLOCK_W;
                w_fill_d  = FILL_W'(w_avail - AVAIL_W'(BLOCK_W));
            end else begin
                w_buf_d  = w_cat;
                w_fill_d = FILL_W'(w_avail);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_buf    <= '0;
            r_fill   <= '0;
            r_slip_p <= 1'b0;
            r_valid  <= 1'b0;
            r_head   <= '0;
            r_data   <= '0;
        end else begin
            r_buf    <= w_buf_d;
            r_fill   <= w_fill_d;
            r_slip_p <= w_slip_p_d;
            r_valid  <= w_valid_d;
            r_head   <= w_head_d;
            r_data   <= w_data_d;
        end
    end

    assign gb.valid_o = r_valid;
    assign gb.head_o  = r_head;
    assign gb.data_o  = r_data;
endmodule

// File: tb/tb_pcs_rx_gearbox.sv
// Directed bench for pcs_rx_gearbox: expected blocks are cut from a bench-held bit stream.
module tb_pcs_rx_gearbox;
    logic clk = 1'b0;
    logic nreset;
    int   n_pass = 0;
    int   n_chk  = 0;
    bit   sq[$];
    int   exp_pos;
    int   n_blk;

    always #5 clk = ~clk;

    pcs_rx_gearbox_if #(.HEAD_W(2), .DATA_W(64)) gb_if ();

    pcs_rx_gearbox #(
        .HEAD_W (2),
        .DATA_W (64),
        .BLOCK_W(66)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .gb    (gb_if.slave)
    );

    function automatic logic [63:0] word_at(input int w);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = (64 * w + i < sq.size()) ? sq[64 * w + i] : 1'b0;
        return r;
    endfunction

    function automatic logic [65:0] blk_at(input int pos);
        logic [65:0] r;
        for (int i = 0; i < 66; i++) r[i] = (pos + i < sq.size()) ? sq[pos + i] : 1'b0;
        return r;
    endfunction

    function automatic bit is_aligned(input logic [1:0] h, input logic [63:0] d);
        return h === (d[0] ? 2'b10 : 2'b01);
    endfunction

    function automatic logic [63:0] nom_word(input int i);
        return {32'hA5A5_0000 | 32'(i), 32'(i)};
    endfunction

    task automatic push_word(input logic [63:0] w);
        for (int i = 0; i < 64; i++) sq.push_back(w[i]);
    endtask

    task automatic push_block(input int k);
        logic [1:0]  h;
        logic [63:0] d;
        h = k[0] ? 2'b10 : 2'b01;
        d = 64'(k);
        sq.push_back(h[0]);
        sq.push_back(h[1]);
        for (int i = 0; i < 64; i++) sq.push_back(d[i]);
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic s);
        @(negedge clk);
        gb_if.serdes_v_i    = v;
        gb_if.serdes_data_i = d;
        gb_if.slip_i        = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        gb_if.serdes_v_i    = 1'b0;
        gb_if.serdes_data_i = '0;
        gb_if.slip_i        = 1'b0;
        nreset              = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        sq.delete();
        exp_pos = 0;
        n_blk   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++;
        if (gb_if.valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", gb_if.valid_o);
        else n_pass++;
        n_chk++;
        if (gb_if.head_o !== 2'b00) $display("FAIL reset_head: got %b want 00", gb_if.head_o);
        else n_pass++;
        n_chk++;
        if (gb_if.data_o !== 64'd0) $display("FAIL reset_data: got %h want 0", gb_if.data_o);
        else n_pass++;
    endtask

    task automatic test_nominal();
        logic [63:0] w0, w1;
        do_reset();
        w0 = nom_word(0);
        w1 = nom_word(1);
        for (int i = 0; i < 33; i++) begin
            push_word(nom_word(i));
            step(1'b1, nom_word(i), 1'b0);
            n_chk++;
            if (gb_if.valid_o !== (i != 0)) $display("FAIL nom_valid[%0d]: got %b want %b", i, gb_if.valid_o, i != 0);
            else n_pass++;
            if (gb_if.valid_o === 1'b1) begin
                n_chk++;
                if ({gb_if.data_o, gb_if.head_o} !== blk_at(exp_pos))
                    $display("FAIL nom_block[%0d]: got %h want %h", n_blk, {gb_if.data_o, gb_if.head_o}, blk_at(exp_pos));
                else n_pass++;
                exp_pos += 66;
                n_blk++;
            end
            if (i == 1) begin
                n_chk++;
                if (gb_if.head_o !== w0[1:0] || gb_if.data_o !== {w1[1:0], w0[63:2]})
                    $display("FAIL nom_first: got %b/%h want %b/%h", gb_if.head_o, gb_if.data_o, w0[1:0], {w1[1:0], w0[63:2]});
                else n_pass++;
            end
        end
        n_chk++;
        if (n_blk != 32) $display("FAIL nom_count: got %0d want 32", n_blk);
        else n_pass++;
        step(1'b1, nom_word(33), 1'b0);
        n_chk++;
        if (gb_if.valid_o !== 1'b0) $display("FAIL nom_refill: got %b want 0", gb_if.valid_o);
        else n_pass++;
    endtask

    task automatic test_loopback();
        do_reset();
        for (int k = 0; k < 100; k++) push_block(k);
        for (int w = 0; w < 104; w++) begin
            step(1'b1, word_at(w), 1'b0);
            if (gb_if.valid_o === 1'b1) begin
                n_chk++;
                if ({gb_if.data_o, gb_if.head_o} !== blk_at(exp_pos))
                    $display("FAIL loop_block[%0d]: got %h want %h", n_blk, {gb_if.data_o, gb_if.head_o}, blk_at(exp_pos));
                else n_pass++;
                exp_pos += 66;
                n_blk++;
            end
        end
        n_chk++;
        if (n_blk != 100) $display("FAIL loop_count: got %0d want 100", n_blk);
        else n_pass++;
    endtask

    task automatic test_slip();
        int          w;
        int          cnt;
        bit          first;
        logic [63:0] prev;
        do_reset();
        sq.push_back(1'b1); sq.push_back(1'b0); sq.push_back(1'b1);
        sq.push_back(1'b1); sq.push_back(1'b0);
        for (int k = 0; k < 160; k++) push_block(k);
        w = 0;
        for (int n = 0; n < 5; n++) begin
            cnt = 0;
            while (cnt < 4) begin
                step(1'b1, word_at(w), 1'b0);
                w++;
                if (gb_if.valid_o === 1'b1) cnt++;
            end
            if (n == 4) begin
                n_chk++;
                if (is_aligned(gb_if.head_o, gb_if.data_o))
                    $display("FAIL slip_four: got aligned %b/%h want misaligned", gb_if.head_o, gb_if.data_o);
                else n_pass++;
            end
            step(1'b1, word_at(w), 1'b1);
            w++;
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                for (int n = 0; n < 66; n++) begin
                    step(1'b1, word_at(w), 1'b1);
                    w++;
                end
            end
            step(1'b1, word_at(w), 1'b0);
            w++;
            first = 1'b1;
            prev  = '0;
            for (int n = 0; n < 20; n++) begin
                step(1'b1, word_at(w), 1'b0);
                w++;
                if (gb_if.valid_o === 1'b1) begin
                    n_chk++;
                    if (!is_aligned(gb_if.head_o, gb_if.data_o) || (!first && gb_if.data_o !== prev + 64'd1))
                        $display("FAIL slip_align[%0d]: got %b/%h prev %h", pass, gb_if.head_o, gb_if.data_o, prev);
                    else n_pass++;
                    prev  = gb_if.data_o;
                    first = 1'b0;
                end
            end
        end
    endtask

    task automatic test_gap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push_word(nom_word(i));
            step(1'b1, nom_word(i), 1'b0);
            if (gb_if.valid_o === 1'b1) begin
                n_chk++;
                if ({gb_if.data_o, gb_if.head_o} !== blk_at(exp_pos))
                    $display("FAIL gap_block[%0d]: got %h want %h", n_blk, {gb_if.data_o, gb_if.head_o}, blk_at(exp_pos));
                else n_pass++;
                exp_pos += 66;
                n_blk++;
            end
            if (i == 10) begin
                for (int g = 0; g < 5; g++) begin
                    step(1'b0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
                    n_chk++;
                    if (gb_if.valid_o !== 1'b0) $display("FAIL gap_idle[%0d]: got %b want 0", g, gb_if.valid_o);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (n_blk != 19) $display("FAIL gap_count: got %0d want 19", n_blk);
        else n_pass++;
    endtask

    task automatic test_slip_corner();
        logic [63:0] wv[13];
        do_reset();
        for (int i = 0; i < 13; i++) begin
            wv[i] = {32'h5A00_0000 | 32'(i * 7), 32'hC3C3_0000 | 32'(i)};
            push_word(wv[i]);
        end
        // Three words leave bits 132.. pending, so the slip must remove stream bit 132.
        sq.delete(132);
        for (int i = 0; i < 13; i++) begin
            step(1'b1, wv[i], 1'b0);
            if (gb_if.valid_o === 1'b1) begin
                n_chk++;
                if ({gb_if.data_o, gb_if.head_o} !== blk_at(exp_pos))
                    $display("FAIL corner_block[%0d]: got %h want %h", n_blk, {gb_if.data_o, gb_if.head_o}, blk_at(exp_pos));
                else n_pass++;
                exp_pos += 66;
                n_blk++;
            end
            if (i == 2) begin
                for (int s = 0; s < 3; s++) begin
                    step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
                    n_chk++;
                    if (gb_if.valid_o !== 1'b0) $display("FAIL corner_idle[%0d]: got %b want 0", s, gb_if.valid_o);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (n_blk != 12) $display("FAIL corner_count: got %0d want 12", n_blk);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [63:0] v0, v1;
        do_reset();
        for (int i = 0; i < 13; i++) step(1'b1, nom_word(i), 1'b0);
        n_chk++;
        if (gb_if.valid_o !== 1'b1 || gb_if.data_o === 64'd0)
            $display("FAIL arst_pre: got %b/%h want 1/nonzero", gb_if.valid_o, gb_if.data_o);
        else n_pass++;
        #3;
        nreset           = 1'b0;
        gb_if.serdes_v_i = 1'b0;
        #1;
        n_chk++;
        if (gb_if.valid_o !== 1'b0) $display("FAIL arst_valid: got %b want 0", gb_if.valid_o);
        else n_pass++;
        n_chk++;
        if (gb_if.head_o !== 2'b00) $display("FAIL arst_head: got %b want 00", gb_if.head_o);
        else n_pass++;
        n_chk++;
        if (gb_if.data_o !== 64'd0) $display("FAIL arst_data: got %h want 0", gb_if.data_o);
        else n_pass++;
        @(negedge clk);
        nreset = 1'b1;
        v0 = 64'h1357_9BDF_2468_ACE1;
        v1 = 64'hFEDC_BA98_7654_3213;
        step(1'b1, v0, 1'b0);
        n_chk++;
        if (gb_if.valid_o !== 1'b0) $display("FAIL arst_w0: got %b want 0", gb_if.valid_o);
        else n_pass++;
        step(1'b1, v1, 1'b0);
        n_chk++;
        if (gb_if.valid_o !== 1'b1 || gb_if.head_o !== v0[1:0] || gb_if.data_o !== {v1[1:0], v0[63:2]})
            $display("FAIL arst_first: got %b/%b/%h want 1/%b/%h", gb_if.valid_o, gb_if.head_o, gb_if.data_o,
                     v0[1:0], {v1[1:0], v0[63:2]});
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        nreset              = 1'b1;
        gb_if.serdes_v_i    = 1'b0;
        gb_if.serdes_data_i = '0;
        gb_if.slip_i        = 1'b0;
        test_reset();
        test_nominal();
        test_loopback();
        test_slip();
        test_gap();
        test_slip_corner();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
